// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets, mem_op codes,
// FSM encoding and access-decode helpers.
package mem_stage_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int EXE2MEM_W  = 106;
  localparam int MEM2WB_W   = 102;

  // EXE->MEM bus: {mem_op, store_data, alu_result, wdest, we, pc}
  localparam int E2M_PC_LSB    = 0;
  localparam int E2M_WE_BIT    = 32;
  localparam int E2M_WDEST_LSB = 33;
  localparam int E2M_ALU_LSB   = 38;
  localparam int E2M_SD_LSB    = 70;
  localparam int E2M_OP_LSB    = 102;

  // MEM->WB bus: {wdest, we, mem_result, dm_addr, pc}
  localparam int M2W_PC_LSB    = 0;
  localparam int M2W_ADDR_LSB  = 32;
  localparam int M2W_RES_LSB   = 64;
  localparam int M2W_WE_BIT    = 96;
  localparam int M2W_WDEST_LSB = 97;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Codes 9..15 decode as NONE.
  function automatic logic op_is_mem(input logic [3:0] op);
    case (op)
      MOP_NONE:                                  op_is_mem = 1'b0;
      MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW,
      MOP_SB, MOP_SH, MOP_SW:                    op_is_mem = 1'b1;
      default:                                   op_is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW: op_is_load = 1'b1;
      default:                                  op_is_load = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: op_misaligned = lo[0];
      MOP_LW, MOP_SW:          op_misaligned = |lo;
      default:                 op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data alignment: picks the byte/half lane addressed by lane and
// sign- or zero-extends it according to the load type.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]       mem_op,
  input  logic [1:0]       lane,
  input  logic [REG_W-1:0] rdata,
  output logic [REG_W-1:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection
  always_comb begin
    byte_s = 8'h00;
    case (lane)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (lane[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension by load type
  always_comb begin
    data = rdata;
    case (mem_op)
      MOP_LB:  data = {{24{byte_s[7]}}, byte_s};
      MOP_LBU: data = {24'h000000, byte_s};
      MOP_LH:  data = {{16{half_s[15]}}, half_s};
      MOP_LHU: data = {16'h0000, half_s};
      MOP_LW:  data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack data-memory handshake,
// extends load data and drives the registered MEM->WB bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EXE2MEM_W-1:0]  exe2mem_bus_ri,
  input  logic                  ctl_mem_valid_i,
  output logic                  ctl_mem_allowin_o,
  output logic                  ctl_mem_over_o,
  output logic [REG_ADDR_W-1:0] ctl_mem_dest_o,
  output logic                  ctl_mem_ale_o,
  input  logic                  wb_allowin_i,
  output logic [MEM2WB_W-1:0]   mem2wb_bus_ro,
  output logic                  ctl_wb_valid_o,
  output logic                  dm_req_o,
  output logic [3:0]            dm_we_o,
  output logic [REG_W-1:0]      dm_addr_o,
  output logic [REG_W-1:0]      dm_wdata_o,
  input  logic                  dm_ack_i,
  input  logic [REG_W-1:0]      dm_rdata_i
);

  logic [3:0]            mem_op_s;
  logic [REG_W-1:0]      sd_s;
  logic [REG_W-1:0]      alu_s;
  logic [REG_ADDR_W-1:0] wdest_s;
  logic                  we_s;
  logic [REG_W-1:0]      pc_s;

  assign mem_op_s = exe2mem_bus_ri[E2M_OP_LSB +: 4];
  assign sd_s     = exe2mem_bus_ri[E2M_SD_LSB +: REG_W];
  assign alu_s    = exe2mem_bus_ri[E2M_ALU_LSB +: REG_W];
  assign wdest_s  = exe2mem_bus_ri[E2M_WDEST_LSB +: REG_ADDR_W];
  assign we_s     = exe2mem_bus_ri[E2M_WE_BIT];
  assign pc_s     = exe2mem_bus_ri[E2M_PC_LSB +: REG_W];

  mem_state_e       state_r;
  logic [REG_W-1:0] result_r;
  logic             wb_valid_r;
  logic [MEM2WB_W-1:0] wb_bus_r;

  logic             is_mem_s;
  logic             is_load_s;
  logic             mis_s;
  logic             req_s;
  logic             over_s;
  logic [3:0]       strb_s;
  logic [REG_W-1:0] wdata_s;
  logic [REG_W-1:0] load_data_s;
  logic [REG_W-1:0] mem_result_s;

  // Access decode
  always_comb begin
    is_mem_s  = op_is_mem(mem_op_s);
    is_load_s = op_is_load(mem_op_s);
    mis_s     = op_misaligned(mem_op_s, alu_s[1:0]);
  end

  // Store byte strobes and lane-replicated write data
  always_comb begin
    strb_s  = 4'h0;
    wdata_s = sd_s;
    case (mem_op_s)
      MOP_SB: begin
        strb_s  = 4'b0001 << alu_s[1:0];
        wdata_s = {4{sd_s[7:0]}};
      end
      MOP_SH: begin
        strb_s  = 4'b0011 << alu_s[1:0];
        wdata_s = {2{sd_s[15:0]}};
      end
      MOP_SW: begin
        strb_s  = 4'hF;
        wdata_s = sd_s;
      end
      default: begin
        strb_s  = 4'h0;
        wdata_s = sd_s;
      end
    endcase
  end

  // Request generation; REQ keeps asserting until the ack arrives
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      ST_IDLE: req_s = ctl_mem_valid_i & is_mem_s & ~mis_s;
      ST_REQ:  req_s = 1'b1;
      ST_DONE: req_s = 1'b0;
      default: req_s = 1'b0;
    endcase
  end

  // Stage completion and result selection
  always_comb begin
    over_s = ctl_mem_valid_i & (~is_mem_s | mis_s | (state_r == ST_DONE));
    if (is_load_s & ~mis_s) begin
      mem_result_s = result_r;
    end else begin
      mem_result_s = alu_s;
    end
  end

  load_ext u_load_ext (
    .mem_op (mem_op_s),
    .lane   (alu_s[1:0]),
    .rdata  (dm_rdata_i),
    .data   (load_data_s)
  );

  // Access FSM; the result register captures load data on the ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      result_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && dm_ack_i) begin
            state_r  <= ST_DONE;
            result_r <= load_data_s;
          end else if (req_s) begin
            state_r <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (dm_ack_i) begin
            state_r  <= ST_DONE;
            result_r <= load_data_s;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (over_s && wb_allowin_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // MEM->WB pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_r <= 1'b0;
      wb_bus_r   <= '0;
    end else if (over_s && wb_allowin_i) begin
      wb_valid_r <= 1'b1;
      wb_bus_r   <= {wdest_s, we_s & ~mis_s, mem_result_s, alu_s, pc_s};
    end else if (wb_allowin_i) begin
      wb_valid_r <= 1'b0;
    end else begin
      wb_valid_r <= wb_valid_r;
    end
  end

  assign dm_req_o          = req_s;
  assign dm_we_o           = req_s ? strb_s : 4'h0;
  assign dm_addr_o         = {alu_s[31:2], 2'b00};
  assign dm_wdata_o        = wdata_s;
  assign ctl_mem_over_o    = over_s;
  assign ctl_mem_allowin_o = ~ctl_mem_valid_i | (over_s & wb_allowin_i);
  assign ctl_mem_dest_o    = wdest_s & {REG_ADDR_W{ctl_mem_valid_i}};
  assign ctl_mem_ale_o     = ctl_mem_valid_i & is_mem_s & mis_s;
  assign ctl_wb_valid_o    = wb_valid_r;
  assign mem2wb_bus_ro     = wb_bus_r;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table with a WB scoreboard plus hand-written
// sequences for WB back-pressure and reset during an outstanding request.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [105:0] exe2mem_bus;
  logic         mem_valid;
  logic         mem_allowin;
  logic         mem_over;
  logic [4:0]   mem_dest;
  logic         mem_ale;
  logic         wb_allowin;
  logic [101:0] wb_bus;
  logic         wb_valid;
  logic         dm_req;
  logic [3:0]   dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic         dm_ack;
  logic [31:0]  dm_rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exe2mem_bus_ri    (exe2mem_bus),
    .ctl_mem_valid_i   (mem_valid),
    .ctl_mem_allowin_o (mem_allowin),
    .ctl_mem_over_o    (mem_over),
    .ctl_mem_dest_o    (mem_dest),
    .ctl_mem_ale_o     (mem_ale),
    .wb_allowin_i      (wb_allowin),
    .mem2wb_bus_ro     (wb_bus),
    .ctl_wb_valid_o    (wb_valid),
    .dm_req_o          (dm_req),
    .dm_we_o           (dm_we),
    .dm_addr_o         (dm_addr),
    .dm_wdata_o        (dm_wdata),
    .dm_ack_i          (dm_ack),
    .dm_rdata_i        (dm_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          d;
    logic        we_in;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] res;
    logic        chk_res;
    logic        ale;
  } vec_t;

  typedef struct {
    logic [101:0] bus;
    logic [101:0] mask;
  } wb_exp_t;

  vec_t    vecs[$];
  wb_exp_t sb_q[$];

  localparam logic [31:0] JUNK = 32'hA5A5_5A5A;

  task automatic check(input string name, input logic [101:0] act, input logic [101:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] wd, input logic we, input logic [31:0] res,
                          input logic chk_res, input logic [31:0] addr, input logic [31:0] pc);
    wb_exp_t e;
    e.bus  = {wd, we, res, addr, pc};
    e.mask = {5'h1F, 1'b1, chk_res ? 32'hFFFF_FFFF : 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    wb_exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h", name, wb_bus);
    end else begin
      e = sb_q.pop_front();
      check(name, wb_bus & e.mask, e.bus & e.mask);
    end
  endtask

  // Runs one instruction through MEM with WB always ready; ack after v.d request cycles.
  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0]  wd;
    logic [31:0] pc;
    bit aligned_mem, exp_req, exp_over, done;
    wd = 5'(idx + 1);
    pc = 32'h1000 + 32'(idx * 4);
    aligned_mem = (v.op >= 4'd1) && (v.op <= 4'd8) && !v.ale;
    done = 1'b0;
    @(negedge clk);
    exe2mem_bus = {v.op, v.sd, v.addr, wd, v.we_in, pc};
    mem_valid   = 1'b1;
    wb_allowin  = 1'b1;
    for (int cyc = 0; cyc < 16 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      exp_req  = aligned_mem && (cyc <= v.d);
      exp_over = aligned_mem ? (cyc == v.d + 1) : (cyc == 0);
      dm_ack   = exp_req && (cyc == v.d);
      dm_rdata = dm_ack ? v.rdata : JUNK;
      #1;
      check($sformatf("v%0d.c%0d over", idx, cyc), mem_over, exp_over);
      check($sformatf("v%0d.c%0d req", idx, cyc), dm_req, exp_req);
      check($sformatf("v%0d.c%0d allowin", idx, cyc), mem_allowin, exp_over);
      check($sformatf("v%0d.c%0d ale", idx, cyc), mem_ale, exp_over && v.ale);
      if (cyc == 0) check($sformatf("v%0d dest", idx), mem_dest, wd);
      if (exp_req) begin
        check($sformatf("v%0d.c%0d addr", idx, cyc), dm_addr, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d.c%0d strb", idx, cyc), dm_we, v.strb);
        if (v.strb != 4'h0) check($sformatf("v%0d.c%0d wdata", idx, cyc), dm_wdata, v.wdata);
      end else begin
        check($sformatf("v%0d.c%0d strb_idle", idx, cyc), dm_we, 4'h0);
      end
      if (exp_over) push_exp(wd, v.we_in & ~v.ale, v.res, v.chk_res, v.addr, pc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.c%0d wb_valid", idx, cyc), wb_valid, exp_over);
      if (exp_over) pop_check($sformatf("v%0d wb_bus", idx));
      done = exp_over;
    end
    @(negedge clk);
    mem_valid = 1'b0;
    dm_ack    = 1'b0;
    #1;
    check($sformatf("v%0d idle req", idx), dm_req, 1'b0);
    check($sformatf("v%0d idle over", idx), mem_over, 1'b0);
    check($sformatf("v%0d idle dest", idx), mem_dest, 5'd0);
    check($sformatf("v%0d idle allowin", idx), mem_allowin, 1'b1);
  endtask

  initial begin
    rst_n       = 1'b0;
    exe2mem_bus = '0;
    mem_valid   = 1'b0;
    wb_allowin  = 1'b1;
    dm_ack      = 1'b0;
    dm_rdata    = 32'h0;

    //                op       addr          sd            rdata        d  we    strb     wdata         res           chk  ale
    vecs.push_back(vec_t'{MOP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b1, 4'h0,    32'h0,        32'hDEADBEEF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LB,  32'h103, 32'h0,        32'h80112233, 1, 1'b1, 4'h0,    32'h0,        32'hFFFFFF80, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LBU, 32'h103, 32'h0,        32'h80112233, 0, 1'b1, 4'h0,    32'h0,        32'h00000080, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_SH,  32'h202, 32'h1234ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCDABCD, 32'h00000202, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LW,  32'h101, 32'h0,        32'h0,        0, 1'b1, 4'h0,    32'h0,        32'h0,        1'b0, 1'b1});
    vecs.push_back(vec_t'{MOP_NONE,32'h12345678, 32'h0,   32'h0,        0, 1'b1, 4'h0,    32'h0,        32'h12345678, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LH,  32'h102, 32'h0,        32'h80017FFF, 2, 1'b1, 4'h0,    32'h0,        32'hFFFF8001, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LHU, 32'h102, 32'h0,        32'h80017FFF, 0, 1'b1, 4'h0,    32'h0,        32'h00008001, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LH,  32'h100, 32'h0,        32'h12348765, 0, 1'b1, 4'h0,    32'h0,        32'hFFFF8765, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_SB,  32'h301, 32'h000000A5, 32'h0,        1, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h00000301, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_SW,  32'h400, 32'hCAFEF00D, 32'h0,        0, 1'b0, 4'hF,    32'hCAFEF00D, 32'h00000400, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_SW,  32'h402, 32'hCAFEF00D, 32'h0,        0, 1'b0, 4'h0,    32'h0,        32'h00000402, 1'b1, 1'b1});
    vecs.push_back(vec_t'{MOP_SH,  32'h203, 32'h1234ABCD, 32'h0,        0, 1'b0, 4'h0,    32'h0,        32'h00000203, 1'b1, 1'b1});
    vecs.push_back(vec_t'{4'd12,   32'h55,  32'h0,        32'h0,        0, 1'b1, 4'h0,    32'h0,        32'h00000055, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LB,  32'h100, 32'h0,        32'h0000007F, 0, 1'b1, 4'h0,    32'h0,        32'h0000007F, 1'b1, 1'b0});
    vecs.push_back(vec_t'{MOP_LHU, 32'h101, 32'h0,        32'h0,        0, 1'b1, 4'h0,    32'h0,        32'h0,        1'b0, 1'b1});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst wb_valid", wb_valid, 1'b0);
    check("rst wb_bus", wb_bus, 102'h0);
    check("rst req", dm_req, 1'b0);
    check("rst over", mem_over, 1'b0);
    check("rst ale", mem_ale, 1'b0);
    check("rst dest", mem_dest, 5'd0);
    check("rst dm_we", dm_we, 4'h0);
    check("rst allowin", mem_allowin, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // WB back-pressure: load completes while WB is stalled for two cycles
    @(negedge clk);
    exe2mem_bus = {MOP_LW, 32'h0, 32'h100, 5'd7, 1'b1, 32'h2000};
    mem_valid   = 1'b1;
    wb_allowin  = 1'b0;
    dm_ack      = 1'b1;
    dm_rdata    = 32'h0BADF00D;
    #1;
    check("stall c0 req", dm_req, 1'b1);
    check("stall c0 allowin", mem_allowin, 1'b0);
    @(posedge clk);
    #1;
    check("stall c0 wb_valid", wb_valid, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      dm_ack     = 1'b0;
      dm_rdata   = JUNK;
      wb_allowin = (c == 3);
      #1;
      check($sformatf("stall c%0d over", c), mem_over, 1'b1);
      check($sformatf("stall c%0d req", c), dm_req, 1'b0);
      check($sformatf("stall c%0d allowin", c), mem_allowin, c == 3);
      if (c == 3) push_exp(5'd7, 1'b1, 32'h0BADF00D, 1'b1, 32'h100, 32'h2000);
      @(posedge clk);
      #1;
      check($sformatf("stall c%0d wb_valid", c), wb_valid, c == 3);
      if (c == 3) pop_check("stall wb_bus");
    end
    @(negedge clk);
    mem_valid = 1'b0;

    // Reset while a request is outstanding and WB holds a valid entry
    @(negedge clk);
    exe2mem_bus = {MOP_NONE, 32'h0, 32'h77, 5'd3, 1'b1, 32'h3000};
    mem_valid   = 1'b1;
    wb_allowin  = 1'b1;
    @(negedge clk);
    exe2mem_bus = {MOP_LW, 32'h0, 32'h200, 5'd4, 1'b1, 32'h3004};
    wb_allowin  = 1'b0;
    dm_ack      = 1'b0;
    #1;
    check("rreq c0 req", dm_req, 1'b1);
    @(posedge clk);
    #1;
    check("rreq c0 wb_valid", wb_valid, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rreq c1 req", dm_req, 1'b1);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    #1;
    check("rreq post req", dm_req, 1'b0);
    check("rreq post wb_valid", wb_valid, 1'b0);
    check("rreq post wb_bus", wb_bus, 102'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    wb_allowin = 1'b1;

    run_vec(vecs[0], 20);
    run_vec(vecs[3], 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, between EXE and WB. Takes the registered EXE->MEM bus, runs loads and stores against the data memory over a req/ack handshake, extends load data, and drives the registered MEM->WB bus plus valid to the write-back stage. It also feeds the hazard unit with the current destination register and its stage-complete status.

## Interface
Parameters:
- none; all widths come from `common.vh` (`RegW`=32, `RegAddrBusW`=5, `EXE2MEMBusSize`=106, `MEM2WBBusSize`=102).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- exe2mem_bus_ri  in  106  {mem_op[3:0], store_data[31:0], alu_result[31:0], wdest[4:0], we, pc[31:0]}
- ctl_mem_valid_i  in  1  bus holds a live instruction
- ctl_mem_allowin_o  out  1  upstream may load a new instruction at the next edge
- ctl_mem_over_o  out  1  instruction finished in MEM this cycle
- ctl_mem_dest_o  out  5  wdest & {5{valid}}, for the hazard unit
- ctl_mem_ale_o  out  1  address-misaligned flag, high together with over
- wb_allowin_i  in  1  WB accepts at the next edge
- mem2wb_bus_ro  out  102  registered {wdest, we, mem_result, dm_addr, pc}
- ctl_wb_valid_o  out  1  registered valid for WB
- dm_req_o  out  1  data-memory request
- dm_we_o  out  4  byte write strobes; all zero for a load
- dm_addr_o  out  32  {alu_result[31:2], 2'b00}
- dm_wdata_o  out  32  lane-replicated store data
- dm_ack_i  in  1  request accepted and completed; rdata valid in the same cycle
- dm_rdata_i  in  32  load word

## Operation
- mem_op encoding: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Codes 9–15 are treated as NONE.
- Misalignment rules:
  - LH, LHU, SH misaligned when addr[0]=1.
  - LW, SW misaligned when addr[1:0]≠0.
- Behaviour on a misaligned access:
  - No request is issued.
  - The instruction completes at once with we forced to 0 and ale=1.
- FSM states: IDLE, REQ, DONE.
  - IDLE: dm_req_o = valid & memop & aligned.
    - Go to REQ if the request is not acked.
    - Go to DONE if it is acked in the same cycle; load the result register.
  - REQ: dm_req_o=1 and the address, strobes and wdata are held stable. On ack, load the result register and go to DONE.
  - DONE: dm_req_o=0. Go to IDLE when over & wb_allowin.
- over is asserted when valid and any of the following holds:
  - mem_op is NONE,
  - the access is misaligned,
  - state=DONE.
- allowin = ~valid | (over & wb_allowin).
- Stores:
  - SB: strobe 4'b0001<<addr[1:0], wdata {4{sd[7:0]}}.
  - SH: strobe 4'b0011<<addr[1:0], wdata {2{sd[15:0]}}.
  - SW: strobe 4'hF, wdata sd.
- Loads: select the byte or half lane from addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- mem_result is the extended load data for loads and alu_result otherwise. The dm_addr field carries the full alu_result.

## Timing
- Reset values: state=IDLE, ctl_wb_valid_o=0, mem2wb_bus_ro=0, result register=0.
- With no valid instruction: dm_req_o=0, ctl_mem_over_o=0, ctl_mem_ale_o=0, ctl_mem_dest_o=0, dm_we_o=0.
- MEM->WB register update at each edge:
  - If over & wb_allowin: load the bus and set valid=1.
  - Else if wb_allowin: valid=0.
  - Else: hold.
- Latency:
  - NONE or misaligned: over in the arrival cycle.
  - Memory op with ack in the request cycle: over one cycle later.
  - In general: over one cycle after the ack.
- A request that is acked is never re-issued for the same instruction.
- In DONE with WB stalled, the result is held indefinitely.
- Reset in REQ or DONE returns to IDLE and drops dm_req_o at that edge; data memory tolerates the abandoned request.

## Structure
- Shared package/`common.vh`:
  - mem_op codes,
  - FSM state encoding,
  - both bus widths and field offsets.
- One natural sub-module, `load_ext`, which is combinational: lane select plus sign/zero extension. Everything else stays in `mem_stage`.

## Test plan
- LW addr 0x100, ack in the request cycle, rdata 0xDEADBEEF -> over the next cycle; WB bus carries mem_result=0xDEADBEEF with we=1.
- LB addr 0x103, rdata 0x80112233 -> mem_result 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, sd 0x1234ABCD, ack delayed 3 cycles -> dm_we=4'b1100, wdata 0xABCDABCD held stable all 4 cycles, one request only, over after the ack.
- LW addr 0x101 -> no dm_req; over and ale in the same cycle; WB bus we=0.
- Load done while wb_allowin=0 for 2 cycles -> allowin=0, bus held; transfer on the first cycle with wb_allowin=1.
- rst_n low during REQ -> next cycle dm_req=0, ctl_wb_valid_o=0, state IDLE.
